// File: rtl/fft_sched_pkg.sv
// Shared constants, state encoding and helpers for the two-channel FFT core scheduler.
package fft_sched_pkg;

  localparam int NFFT_W       = 5;
  localparam int CNT_W        = 12;
  localparam int SCH_NBIT_DEF = 12;

  localparam logic [NFFT_W-1:0] NFFT_MIN = 5'd7;
  localparam logic [NFFT_W-1:0] NFFT_MAX = 5'd11;
  localparam logic [NFFT_W-1:0] NFFT_RST = 5'd11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_START,
    ST_LOAD,
    ST_WAIT_DONE,
    ST_UNLOAD,
    ST_DRAIN
  } state_t;

  function automatic logic nfft_ok(input logic [NFFT_W-1:0] n);
    return (n >= NFFT_MIN) && (n <= NFFT_MAX);
  endfunction

  function automatic logic [CNT_W-1:0] npoints(input logic [NFFT_W-1:0] n);
    return CNT_W'(1) << n;
  endfunction

endpackage

// File: rtl/fft_sched_rr.sv
// Two-way round-robin arbiter; remembers which channel finished last.
module fft_sched_rr (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] valid,
  input  logic       rec_en,
  input  logic       rec_ch,
  output logic [1:0] grant
);

  logic last_q, last_d;

  always_comb begin
    last_d = rec_en ? rec_ch : last_q;
    unique case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Reset to channel 1 so channel 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_q <= 1'b1;
    else          last_q <= last_d;
  end

endmodule

// File: rtl/fft_sched.sv
// Schedules transform jobs from two channels onto one FFT core: config, load, wait, drain.
//   state     | meaning
//   IDLE      | arbitrate requests, latch config of the winner
//   CFG       | write-enable pulse for nfft/inv/scale
//   START     | core_start pulse, sample counter loaded
//   LOAD      | stream samples while core_rfd, count down
//   WAIT_DONE | wait for core_done
//   UNLOAD    | core_unload pulse, counter reloaded
//   DRAIN     | count core_dv results, release grant on last
module fft_sched
  import fft_sched_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int SCH_NBIT  = SCH_NBIT_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           req,
  input  logic [4:0]           ch0_nfft,
  input  logic [4:0]           ch1_nfft,
  input  logic                 ch0_inv,
  input  logic                 ch1_inv,
  input  logic [SCH_NBIT-1:0]  ch0_scale,
  input  logic [SCH_NBIT-1:0]  ch1_scale,
  input  logic [BIT_WIDTH-1:0] ch0_xn_re,
  input  logic [BIT_WIDTH-1:0] ch0_xn_im,
  input  logic [BIT_WIDTH-1:0] ch1_xn_re,
  input  logic [BIT_WIDTH-1:0] ch1_xn_im,
  output logic [1:0]           gnt,
  output logic [1:0]           xn_rd,
  output logic [1:0]           err,
  output logic [4:0]           core_nfft,
  output logic                 core_nfft_we,
  output logic                 core_inv,
  output logic                 core_inv_we,
  output logic [SCH_NBIT-1:0]  core_scale,
  output logic                 core_scale_we,
  output logic                 core_start,
  output logic                 core_unload,
  output logic [BIT_WIDTH-1:0] core_xn_re,
  output logic [BIT_WIDTH-1:0] core_xn_im,
  input  logic                 core_rfd,
  input  logic                 core_done,
  input  logic                 core_dv,
  output logic                 out_ch,
  output logic                 out_last
);

  state_t              state_q, state_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [1:0]          err_q, err_d;
  logic [NFFT_W-1:0]   nfft_q, nfft_d;
  logic                inv_q, inv_d;
  logic [SCH_NBIT-1:0] scale_q, scale_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic                start_q, start_d;
  logic                unload_q, unload_d;
  logic                out_ch_q, out_ch_d;

  logic [1:0] nfft_good, arb_gnt;
  logic       last_cnt, load_fire, drain_last;

  assign nfft_good  = {nfft_ok(ch1_nfft), nfft_ok(ch0_nfft)};
  assign last_cnt   = (cnt_q == CNT_W'(1));
  assign load_fire  = (state_q == ST_LOAD) && core_rfd;
  assign drain_last = (state_q == ST_DRAIN) && core_dv && last_cnt;

  fft_sched_rr u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .valid   (req & nfft_good),
    .rec_en  (drain_last),
    .rec_ch  (gnt_q[1]),
    .grant   (arb_gnt)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    err_d    = 2'b00;
    nfft_d   = nfft_q;
    inv_d    = inv_q;
    scale_d  = scale_q;
    cnt_d    = cnt_q;
    we_d     = 1'b0;
    start_d  = 1'b0;
    unload_d = 1'b0;
    out_ch_d = out_ch_q;
    case (state_q)
      ST_IDLE: begin
        err_d = req & ~nfft_good;
        if (arb_gnt != 2'b00) begin
          gnt_d   = arb_gnt;
          nfft_d  = arb_gnt[1] ? ch1_nfft  : ch0_nfft;
          inv_d   = arb_gnt[1] ? ch1_inv   : ch0_inv;
          scale_d = arb_gnt[1] ? ch1_scale : ch0_scale;
          we_d    = 1'b1;
          state_d = ST_CFG;
        end
      end
      ST_CFG: begin
        start_d = 1'b1;
        state_d = ST_START;
      end
      ST_START: begin
        cnt_d   = npoints(nfft_q);
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (core_rfd) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (last_cnt) state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (core_done) begin
          unload_d = 1'b1;
          out_ch_d = gnt_q[1];
          cnt_d    = npoints(nfft_q);
          state_d  = ST_UNLOAD;
        end
      end
      ST_UNLOAD: state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (core_dv) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (last_cnt) begin
            gnt_d   = 2'b00;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= 2'b00;
      err_q    <= 2'b00;
      nfft_q   <= NFFT_RST;
      inv_q    <= 1'b0;
      scale_q  <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      start_q  <= 1'b0;
      unload_q <= 1'b0;
      out_ch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      err_q    <= err_d;
      nfft_q   <= nfft_d;
      inv_q    <= inv_d;
      scale_q  <= scale_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      start_q  <= start_d;
      unload_q <= unload_d;
      out_ch_q <= out_ch_d;
    end
  end

  // Sample strobe and last flag must coincide with core_rfd / core_dv, so they stay combinational.
  assign xn_rd         = load_fire ? gnt_q : 2'b00;
  assign out_last      = drain_last;
  assign gnt           = gnt_q;
  assign err           = err_q;
  assign core_nfft     = nfft_q;
  assign core_inv      = inv_q;
  assign core_scale    = scale_q;
  assign core_nfft_we  = we_q;
  assign core_inv_we   = we_q;
  assign core_scale_we = we_q;
  assign core_start    = start_q;
  assign core_unload   = unload_q;
  assign out_ch        = out_ch_q;
  assign core_xn_re    = gnt_q[1] ? ch1_xn_re : (gnt_q[0] ? ch0_xn_re : '0);
  assign core_xn_im    = gnt_q[1] ? ch1_xn_im : (gnt_q[0] ? ch0_xn_im : '0);

endmodule

// File: tb/tb_fft_sched.sv
// Directed bench for fft_sched: arbitration table plus full-job sequences with a simple core stand-in.
module tb_fft_sched;

  localparam int BW = 16;
  localparam int SN = 12;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    req;
  logic [4:0]    ch0_nfft, ch1_nfft;
  logic          ch0_inv, ch1_inv;
  logic [SN-1:0] ch0_scale, ch1_scale;
  logic [BW-1:0] ch0_xn_re, ch0_xn_im, ch1_xn_re, ch1_xn_im;
  logic [1:0]    gnt, xn_rd, err;
  logic [4:0]    core_nfft;
  logic          core_nfft_we, core_inv, core_inv_we, core_scale_we;
  logic [SN-1:0] core_scale;
  logic          core_start, core_unload;
  logic [BW-1:0] core_xn_re, core_xn_im;
  logic          core_rfd, core_done, core_dv;
  logic          out_ch, out_last;

  int checks = 0;
  int errors = 0;

  fft_sched #(.BIT_WIDTH(BW), .SCH_NBIT(SN)) dut (
    .clk(clk), .reset_n(reset_n), .req(req),
    .ch0_nfft(ch0_nfft), .ch1_nfft(ch1_nfft), .ch0_inv(ch0_inv), .ch1_inv(ch1_inv),
    .ch0_scale(ch0_scale), .ch1_scale(ch1_scale),
    .ch0_xn_re(ch0_xn_re), .ch0_xn_im(ch0_xn_im), .ch1_xn_re(ch1_xn_re), .ch1_xn_im(ch1_xn_im),
    .gnt(gnt), .xn_rd(xn_rd), .err(err),
    .core_nfft(core_nfft), .core_nfft_we(core_nfft_we), .core_inv(core_inv), .core_inv_we(core_inv_we),
    .core_scale(core_scale), .core_scale_we(core_scale_we), .core_start(core_start),
    .core_unload(core_unload), .core_xn_re(core_xn_re), .core_xn_im(core_xn_im),
    .core_rfd(core_rfd), .core_done(core_done), .core_dv(core_dv),
    .out_ch(out_ch), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic [4:0] n0;
    logic [4:0] n1;
    logic [1:0] gnt;
    logic [1:0] err;
    logic [4:0] nfft;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req       = 2'b00;
    core_rfd  = 1'b0;
    core_done = 1'b0;
    core_dv   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Called at posedge+1 in IDLE with req already driven; returns at posedge+1 after the job ends.
  task automatic run_job(input logic [1:0] eg, input logic [4:0] en, input logic ei,
                         input logic [SN-1:0] es, input bit tog, input bit mod_mid, input string tag);
    int n, rd, bad, xbad, lastk, limit;
    logic [1:0] exp_rd;
    n = 1 << en;
    cyc();
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".cfg_we"}, 32'({core_nfft_we, core_inv_we, core_scale_we, core_start}), 32'(4'b1110));
    chk({tag, ".cfg_val"}, 32'({core_nfft, core_inv, core_scale}), 32'({en, ei, es}));
    cyc();
    chk({tag, ".start"}, 32'({core_nfft_we, core_inv_we, core_scale_we, core_start}), 32'(4'b0001));
    cyc();
    rd = 0; bad = 0; xbad = 0;
    limit = (tog ? 2 * n : n) + 8;
    for (int i = 0; i < limit; i++) begin
      core_rfd  = tog ? ((i % 2) == 0) : 1'b1;
      ch0_xn_re = BW'(32'h1000 + i);
      ch0_xn_im = BW'(32'h5000 + i);
      ch1_xn_re = BW'(32'h2000 + i);
      ch1_xn_im = BW'(32'h6000 + i);
      #1;
      exp_rd = (core_rfd && rd < n) ? eg : 2'b00;
      if (xn_rd !== exp_rd) bad++;
      if (xn_rd != 2'b00) rd++;
      if (core_xn_re !== (eg[1] ? ch1_xn_re : ch0_xn_re)) xbad++;
      if (core_xn_im !== (eg[1] ? ch1_xn_im : ch0_xn_im)) xbad++;
      if (core_start || core_unload || out_last || core_nfft_we) bad++;
      @(posedge clk);
      #1;
    end
    core_rfd = 1'b0;
    chk({tag, ".rd_count"}, 32'(rd), 32'(n));
    chk({tag, ".rd_bad"}, 32'(bad), 32'd0);
    chk({tag, ".xn_mux"}, 32'(xbad), 32'd0);
    if (mod_mid) begin
      req       = 2'b00;
      ch0_nfft  = 5'd8;  ch1_nfft  = 5'd9;
      ch0_inv   = ~ch0_inv; ch1_inv = ~ch1_inv;
      ch0_scale = 12'h5A5; ch1_scale = 12'h3C3;
    end
    core_done = 1'b1;
    cyc();
    core_done = 1'b0;
    chk({tag, ".unload"}, 32'({core_unload, out_ch}), 32'({1'b1, eg[1]}));
    chk({tag, ".cfg_hold"}, 32'({core_nfft, core_inv, core_scale}), 32'({en, ei, es}));
    cyc();
    chk({tag, ".unload_end"}, 32'(core_unload), 32'd0);
    lastk = 0;
    for (int k = 1; k <= n + 4 && lastk == 0; k++) begin
      core_dv = 1'b1;
      #1;
      if (out_last) lastk = k;
      @(posedge clk);
      #1;
    end
    core_dv = 1'b0;
    chk({tag, ".last_idx"}, 32'(lastk), 32'(n));
    chk({tag, ".post_gnt"}, 32'({gnt, out_ch}), 32'({2'b00, eg[1]}));
  endtask

  initial begin
    int rd;
    ch0_nfft = 5'd9; ch1_nfft = 5'd9;
    ch0_inv = 1'b0; ch1_inv = 1'b0;
    ch0_scale = '0; ch1_scale = '0;
    ch0_xn_re = 16'h1111; ch0_xn_im = 16'h2222;
    ch1_xn_re = 16'h3333; ch1_xn_im = 16'h4444;
    vecs[0] = '{2'b01, 5'd9,  5'd9,  2'b01, 2'b00, 5'd9};
    vecs[1] = '{2'b10, 5'd9,  5'd7,  2'b10, 2'b00, 5'd7};
    vecs[2] = '{2'b11, 5'd8,  5'd9,  2'b01, 2'b00, 5'd8};
    vecs[3] = '{2'b11, 5'd10, 5'd12, 2'b01, 2'b10, 5'd10};
    vecs[4] = '{2'b11, 5'd6,  5'd11, 2'b10, 2'b01, 5'd11};
    vecs[5] = '{2'b01, 5'd12, 5'd9,  2'b00, 2'b01, 5'd11};
    vecs[6] = '{2'b11, 5'd0,  5'd31, 2'b00, 2'b11, 5'd11};
    vecs[7] = '{2'b10, 5'd9,  5'd11, 2'b10, 2'b00, 5'd11};
    vecs[8] = '{2'b00, 5'd3,  5'd9,  2'b00, 2'b00, 5'd11};

    do_reset();
    chk("rst.ctl", 32'({gnt, xn_rd, err, core_nfft_we, core_start, core_unload, out_ch, out_last}), 32'd0);
    chk("rst.cfg", 32'({core_nfft, core_inv, core_scale}), 32'({5'd11, 1'b0, 12'h000}));
    chk("rst.xn", 32'({core_xn_re, core_xn_im}), 32'd0);

    for (int v = 0; v < 9; v++) begin
      do_reset();
      ch0_nfft = vecs[v].n0;
      ch1_nfft = vecs[v].n1;
      req      = vecs[v].req;
      cyc();
      chk($sformatf("vec%0d.gnt", v), 32'(gnt), 32'(vecs[v].gnt));
      chk($sformatf("vec%0d.err", v), 32'(err), 32'(vecs[v].err));
      chk($sformatf("vec%0d.nfft", v), 32'({core_nfft, core_nfft_we}), 32'({vecs[v].nfft, |vecs[v].gnt}));
      req = 2'b00;
      cyc();
      chk($sformatf("vec%0d.err_pulse", v), 32'(err), 32'd0);
    end

    do_reset();
    ch0_nfft = 5'd9; ch0_inv = 1'b1; ch0_scale = 12'hABC;
    req = 2'b01;
    run_job(2'b01, 5'd9, 1'b1, 12'hABC, 1'b0, 1'b0, "job512");
    req = 2'b00;

    do_reset();
    ch1_nfft = 5'd7; ch1_inv = 1'b0; ch1_scale = 12'h123;
    req = 2'b10;
    run_job(2'b10, 5'd7, 1'b0, 12'h123, 1'b1, 1'b0, "rfd_tog");
    req = 2'b00;

    do_reset();
    ch0_nfft = 5'd7; ch0_inv = 1'b0; ch0_scale = 12'h001;
    ch1_nfft = 5'd8; ch1_inv = 1'b1; ch1_scale = 12'h002;
    req = 2'b11;
    run_job(2'b01, 5'd7, 1'b0, 12'h001, 1'b0, 1'b0, "rr_a");
    run_job(2'b10, 5'd8, 1'b1, 12'h002, 1'b0, 1'b0, "rr_b");
    run_job(2'b01, 5'd7, 1'b0, 12'h001, 1'b0, 1'b0, "rr_c");
    req = 2'b00;

    do_reset();
    ch1_nfft = 5'd8; ch1_inv = 1'b1; ch1_scale = 12'h777;
    req = 2'b10;
    run_job(2'b10, 5'd8, 1'b1, 12'h777, 1'b0, 1'b1, "mod_mid");
    cyc();
    chk("mod_mid.idle", 32'(gnt), 32'd0);

    do_reset();
    ch0_nfft = 5'd10; ch0_inv = 1'b0; ch0_scale = 12'h000;
    req = 2'b01;
    cyc(); cyc(); cyc();
    rd = 0;
    for (int i = 0; i < 300; i++) begin
      core_rfd = 1'b1;
      #1;
      if (xn_rd == 2'b01) rd++;
      @(posedge clk);
      #1;
    end
    chk("midrst.rd_count", 32'(rd), 32'd300);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst.ctl", 32'({gnt, xn_rd, err, core_nfft_we, core_start, core_unload, out_ch, out_last}), 32'd0);
    chk("midrst.xn", 32'({core_xn_re, core_xn_im}), 32'd0);
    core_rfd = 1'b0;
    ch0_nfft = 5'd7;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run_job(2'b01, 5'd7, 1'b0, 12'h000, 1'b0, 1'b0, "midrst.job");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_sched.md
FFT_SCHED -- requirements
Module: fft_sched

Interface
REQ-001 Parameter BIT_WIDTH, default 16, sample width of real and imaginary parts.
REQ-002 Parameter SCH_NBIT, default 12, width of the core scale-schedule word.
REQ-003 clk  input  1  single clock; all logic is in this domain.
REQ-004 reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 req  input  2  per-channel transform request; level, held until gnt.
REQ-006 ch0_nfft / ch1_nfft  input  5  per-channel log2 transform size code.
REQ-007 ch0_inv / ch1_inv  input  1  per-channel direction: 0 = FFT, 1 = IFFT.
REQ-008 ch0_scale / ch1_scale  input  SCH_NBIT  per-channel scale schedule.
REQ-009 ch0_xn_re, ch0_xn_im, ch1_xn_re, ch1_xn_im  input  BIT_WIDTH  per-channel samples.
REQ-010 gnt  output  2  one-hot grant; held for the whole job.
REQ-011 xn_rd  output  2  one-hot sample-consume strobe; the channel presents its next sample the following cycle.
REQ-012 err  output  2  one-cycle pulse: the request was rejected for an invalid nfft code.
REQ-013 core_nfft, core_nfft_we, core_inv, core_inv_we, core_scale, core_scale_we, core_start, core_unload  output  5/1/1/1/SCH_NBIT/1/1/1  core configuration and control.
REQ-014 core_xn_re, core_xn_im  output  BIT_WIDTH  muxed samples to the core.
REQ-015 core_rfd, core_done, core_dv  input  1 each  core ready-for-data, done and output-valid.
REQ-016 out_ch  output  1  channel owning the current core_dv results.
REQ-017 out_last  output  1  one-cycle pulse with the last core_dv of a job.

Function
REQ-018 States: IDLE, CFG, START, LOAD, WAIT_DONE, UNLOAD, DRAIN.
REQ-019 IDLE: on any valid req, grant one channel; latch its nfft, inv and scale; go to CFG next cycle.
REQ-020 Valid nfft codes are 7 to 11 (128 to 2048 points).
REQ-021 Invalid nfft code: pulse err[ch] for one cycle, skip that channel this cycle, and stay in IDLE unless the other channel is valid.
REQ-022 Arbitration is round-robin: when both channels are valid, grant the channel not served last. After reset, channel 0 wins the first tie.
REQ-023 CFG: assert nfft_we, inv_we and scale_we together for exactly one cycle with the latched values, then go to START.
REQ-024 START: pulse core_start for one cycle, load the sample counter with 2^nfft, then go to LOAD.
REQ-025 LOAD: each cycle with core_rfd = 1, assert xn_rd[gnt] and decrement the counter. core_rfd = 0 stalls the counter and deasserts xn_rd.
REQ-026 core_xn_re/im equal the granted channel's samples combinationally; they are 0 when nothing is granted.
REQ-027 LOAD ends when the counter reaches 0; go to WAIT_DONE.
REQ-028 WAIT_DONE: wait for core_done, then go to UNLOAD.
REQ-029 UNLOAD: pulse core_unload for one cycle, set out_ch to the granted channel, reload the counter with 2^nfft, then go to DRAIN.
REQ-030 DRAIN: decrement on each core_dv. On the last one, pulse out_last, drop gnt, record the last-served channel, and go to IDLE.
REQ-031 A new grant in IDLE takes effect the cycle after DRAIN exits; back-to-back jobs have no extra idle cycles.
REQ-032 Changes to req or configuration after grant are ignored until the job ends.
REQ-033 Deassertion of req during a job is ignored; the job completes.
REQ-034 The counter is 12 bits wide, which is enough for 2048.

Reset
REQ-035 reset_n low, including mid-job: state goes to IDLE; gnt, xn_rd, err, all core_* strobes, out_last, the counter and out_ch go to 0; last-served is set to channel 1.
REQ-036 Latched nfft, inv and scale reset to 11, 0 and 0.
REQ-037 After reset_n deasserts, the first grant is possible on the first clk edge.

Structure
REQ-038 State encoding, nfft min/max constants and SCH_NBIT default belong in the shared include with the FFT constants.
REQ-039 One sub-module, fft_sched_rr, holds the 2-way round-robin arbiter including last-served tracking.

Verification
REQ-040 Single ch0 job with nfft = 9 and rfd always 1: CFG strobes for one cycle, start after 1 cycle, exactly 512 xn_rd[0], unload the cycle after done, out_last on the 512th dv with out_ch = 0.
REQ-041 Both channels requesting from reset: ch0 is served, then ch1 with no idle cycles between jobs, then ch0 again if it is still requesting.
REQ-042 rfd toggling 1/0 during LOAD with nfft = 7: exactly 128 xn_rd, each coincident with rfd = 1.
REQ-043 ch1 with nfft = 12 and ch0 with nfft = 10 requesting: err = 2'b10 for one cycle, ch0 is granted.
REQ-044 reset_n asserted mid-LOAD with 300 samples sent: all outputs 0 immediately; the next request restarts from CFG.
REQ-045 Config change and req drop during WAIT_DONE: the job completes with the originally latched values.
